// File: rtl/histogram_engine.sv
// histogram_engine
//   Streaming image histogram. A frame runs in three phases: CLEAR zeroes every bin, ACCUM
//   counts NPIX pixels (one per cycle, valid/ready), READOUT streams {bin, count} words in bin
//   order with back-pressure. Counters saturate and raise a sticky sat_o.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   en_i                   global enable; low freezes the whole block
//   start_i                start a frame (honoured in IDLE/DONE only)
//   pix_i/pix_valid_i      pixel (bin index) stream; pix_ready_o accepts it
//   rd_data_o/rd_valid_o   readout word {bin, count}; rd_ready_i back-pressures it
//   rd_last_o              marks the word for bin BINS-1
//   busy_o, done_o, sat_o  status
module histogram_engine #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned CNT_W = 24,
    parameter int unsigned NPIX  = 76800
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   start_i,
    input  logic [PIX_W-1:0]       pix_i,
    input  logic                   pix_valid_i,
    output logic                   pix_ready_o,
    output logic [PIX_W+CNT_W-1:0] rd_data_o,
    output logic                   rd_valid_o,
    input  logic                   rd_ready_i,
    output logic                   rd_last_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   sat_o
);
    localparam int unsigned      Bins    = 2 ** PIX_W;
    localparam int unsigned      PcW     = $clog2(NPIX + 1);
    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [PIX_W-1:0] BinLast = '1;
    localparam logic [PcW-1:0]   PcNpix  = PcW'(NPIX);
    localparam logic [PcW-1:0]   PcLast  = PcW'(NPIX - 1);

    typedef enum logic [2:0] {StIdle, StClear, StAccum, StDrain, StReadout, StDone} state_e;

    state_e                   state_q, state_d;
    logic [PIX_W:0]           ptr_q, ptr_d;         // clear address, then readout issue pointer
    logic [PcW-1:0]           pix_cnt_q, pix_cnt_d;
    logic                     drain_q, drain_d;
    logic                     sat_q, sat_d;
    // Stage 1: bin whose RAM read is in rdata_q. wb_*: the value stage 2 wrote last edge,
    // which the RAM read issued on that same edge could not yet see.
    logic                     s1_vld_q, s1_vld_d;
    logic [PIX_W-1:0]         s1_bin_q, s1_bin_d;
    logic                     wb_vld_q, wb_vld_d;
    logic [PIX_W-1:0]         wb_bin_q, wb_bin_d;
    logic [CNT_W-1:0]         wb_cnt_q, wb_cnt_d;
    // Readout: rp_* tracks the word sitting in rdata_q, rd_* is the output register.
    logic                     rp_vld_q, rp_vld_d;
    logic [PIX_W-1:0]         rp_bin_q, rp_bin_d;
    logic                     rd_valid_q, rd_valid_d;
    logic [PIX_W+CNT_W-1:0]   rd_data_q, rd_data_d;
    logic                     rd_last_q, rd_last_d;

    logic [CNT_W-1:0]         mem [Bins];
    logic [CNT_W-1:0]         rdata_q;
    logic                     ram_we, ram_re;
    logic [PIX_W-1:0]         ram_waddr, ram_raddr;
    logic [CNT_W-1:0]         ram_wdata;
    logic [CNT_W-1:0]         operand;
    logic                     xfer, load_out, issue;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        pix_cnt_d  = pix_cnt_q;
        drain_d    = drain_q;
        sat_d      = sat_q;
        s1_vld_d   = s1_vld_q;
        s1_bin_d   = s1_bin_q;
        wb_vld_d   = wb_vld_q;
        wb_bin_d   = wb_bin_q;
        wb_cnt_d   = wb_cnt_q;
        rp_vld_d   = rp_vld_q;
        rp_bin_d   = rp_bin_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_last_d  = rd_last_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_waddr  = ptr_q[PIX_W-1:0];
        ram_raddr  = pix_i;
        ram_wdata  = '0;
        xfer       = 1'b0;
        load_out   = 1'b0;
        issue      = 1'b0;
        pix_ready_o = 1'b0;
        operand    = (wb_vld_q && (wb_bin_q == s1_bin_q)) ? wb_cnt_q : rdata_q;

        if (!rst_i && en_i) begin
            // Stage 2: increment (saturating) and write back; also runs during DRAIN.
            s1_vld_d = 1'b0;
            wb_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                wb_bin_d = s1_bin_q;
                if (operand == CntMax) begin
                    wb_cnt_d = operand;
                    sat_d    = 1'b1;
                end else begin
                    wb_cnt_d = operand + 1'b1;
                end
                ram_we    = 1'b1;
                ram_waddr = s1_bin_q;
                ram_wdata = wb_cnt_d;
            end

            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        state_d = StClear;
                        ptr_d   = '0;
                    end
                end
                StClear: begin
                    ram_we    = 1'b1;
                    ram_waddr = ptr_q[PIX_W-1:0];
                    ram_wdata = '0;
                    sat_d     = 1'b0;
                    pix_cnt_d = '0;
                    if (ptr_q[PIX_W-1:0] == BinLast) begin
                        ptr_d   = '0;
                        state_d = StAccum;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                StAccum: begin
                    pix_ready_o = (pix_cnt_q < PcNpix);
                    if (pix_ready_o && pix_valid_i) begin
                        ram_re    = 1'b1;
                        ram_raddr = pix_i;
                        s1_vld_d  = 1'b1;
                        s1_bin_d  = pix_i;
                        pix_cnt_d = pix_cnt_q + 1'b1;
                        if (pix_cnt_q == PcLast) begin
                            state_d = StDrain;
                        end
                    end
                end
                StDrain: begin
                    drain_d = ~drain_q;
                    if (drain_q) begin
                        state_d = StReadout;
                    end
                end
                StReadout: begin
                    xfer     = rd_valid_q && rd_ready_i;
                    load_out = rp_vld_q && (!rd_valid_q || xfer);
                    issue    = !ptr_q[PIX_W] && (!rp_vld_q || load_out);
                    if (xfer) begin
                        rd_valid_d = 1'b0;
                    end
                    if (load_out) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = {rp_bin_q, rdata_q};
                        rd_last_d  = (rp_bin_q == BinLast);
                    end
                    rp_vld_d = issue || (rp_vld_q && !load_out);
                    if (issue) begin
                        ram_re    = 1'b1;
                        ram_raddr = ptr_q[PIX_W-1:0];
                        rp_bin_d  = ptr_q[PIX_W-1:0];
                        ptr_d     = ptr_q + 1'b1;
                    end
                    if (xfer && rd_last_q) begin
                        state_d = StDone;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            pix_cnt_q  <= '0;
            drain_q    <= 1'b0;
            sat_q      <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_bin_q   <= '0;
            wb_vld_q   <= 1'b0;
            wb_bin_q   <= '0;
            wb_cnt_q   <= '0;
            rp_vld_q   <= 1'b0;
            rp_bin_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            pix_cnt_q  <= pix_cnt_d;
            drain_q    <= drain_d;
            sat_q      <= sat_d;
            s1_vld_q   <= s1_vld_d;
            s1_bin_q   <= s1_bin_d;
            wb_vld_q   <= wb_vld_d;
            wb_bin_q   <= wb_bin_d;
            wb_cnt_q   <= wb_cnt_d;
            rp_vld_q   <= rp_vld_d;
            rp_bin_q   <= rp_bin_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_last_q  <= rd_last_d;
        end
    end

    // Bin RAM: read-before-write, contents survive reset. rdata_q only moves on a read.
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (ram_re) begin
            rdata_q <= mem[ram_raddr];
        end
    end

    // Outputs are forced low while reset is asserted, not just after the reset edge.
    assign rd_valid_o = rd_valid_q && !rst_i;
    assign rd_data_o  = rst_i ? '0 : rd_data_q;
    assign rd_last_o  = rd_last_q && !rst_i;
    assign sat_o      = sat_q && !rst_i;
    assign done_o     = (state_q == StDone) && !rst_i;
    assign busy_o     = !rst_i && (state_q inside {StClear, StAccum, StDrain, StReadout});

endmodule
